// File: rtl/branch_target_predictor_pkg.sv
// Shared definitions for the IF-stage next-PC predictor: predictor mode
// selector and the 32-bit MIPS opcode / field positions used by decode.
package branch_target_predictor_pkg;

  typedef enum logic [0:0] {
    PRED_BIMODAL = 1'b0,
    PRED_GSHARE  = 1'b1
  } pred_mode_e;

  localparam logic [5:0] OPCODE_J   = 6'h02;
  localparam logic [5:0] OPCODE_JAL = 6'h03;
  localparam logic [5:0] OPCODE_BEQ = 6'h04;

  localparam int unsigned J_TYPE_OP_MSB   = 31;
  localparam int unsigned J_TYPE_OP_LSB   = 26;
  localparam int unsigned J_TYPE_ADDR_MSB = 25;
  localparam int unsigned J_TYPE_ADDR_LSB = 0;
  localparam int unsigned I_TYPE_IMM_MSB  = 15;
  localparam int unsigned I_TYPE_IMM_LSB  = 0;

endpackage

// File: rtl/branch_target_predictor_if.sv
// Fetch/resolve bus of the next-PC predictor.
//   master : pipeline side (drives fetch PC/instr and EX resolution)
//   slave  : predictor side (returns next PC, taken, BTB hit, history)
interface branch_target_predictor_if #(
  parameter int unsigned DWIDTH    = 32,
  parameter int unsigned HIST_BITS = 6
);
  logic [DWIDTH-1:0]    if_pc;
  logic [DWIDTH-1:0]    if_instr;
  logic [DWIDTH-1:0]    if_npc;
  logic                 if_pred_taken;
  logic                 if_btb_hit;
  logic [HIST_BITS-1:0] if_hist;
  logic                 ex_valid;
  logic [DWIDTH-1:0]    ex_pc;
  logic [HIST_BITS-1:0] ex_hist;
  logic                 ex_taken;
  logic [DWIDTH-1:0]    ex_target;

  modport master (
    output if_pc, if_instr, ex_valid, ex_pc, ex_hist, ex_taken, ex_target,
    input  if_npc, if_pred_taken, if_btb_hit, if_hist
  );

  modport slave (
    input  if_pc, if_instr, ex_valid, ex_pc, ex_hist, ex_taken, ex_target,
    output if_npc, if_pred_taken, if_btb_hit, if_hist
  );
endinterface

// File: rtl/branch_target_predictor_sat_counter_table.sv
// sat_counter_table: array of saturating counters (the PHT).
//   clk, rst       : clock, synchronous active-high reset (all counters -> INIT)
//   i_rd_idx       : combinational read index -> o_rd_cnt_c
//   i_upd_en/_inc  : increment (inc=1) or decrement entry i_upd_idx on the edge
module sat_counter_table #(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned CNT_BITS = 2,
  parameter int unsigned INIT     = 2,
  localparam int unsigned IDX_W   = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_W-1:0]    i_rd_idx,
  output logic [CNT_BITS-1:0] o_rd_cnt_c,
  input  logic                i_upd_en,
  input  logic                i_upd_inc,
  input  logic [IDX_W-1:0]    i_upd_idx
);

  localparam logic [CNT_BITS-1:0] CNT_MAX  = CNT_BITS'((1 << CNT_BITS) - 1);
  localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'(INIT);

  logic [CNT_BITS-1:0] r_cnt [DEPTH];
  logic [CNT_BITS-1:0] w_cur;
  logic [CNT_BITS-1:0] w_nxt;

  assign o_rd_cnt_c = r_cnt[i_rd_idx];

  // Saturating next value for the entry being trained
  always_comb begin
    w_cur = r_cnt[i_upd_idx];
    w_nxt = w_cur;
    if (i_upd_inc) begin
      if (w_cur != CNT_MAX) w_nxt = w_cur + CNT_BITS'(1);
    end else begin
      if (w_cur != '0) w_nxt = w_cur - CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_cnt[i] <= CNT_INIT;
    end else if (i_upd_en) begin
      r_cnt[i_upd_idx] <= w_nxt;
    end
  end

endmodule

// File: rtl/branch_target_predictor.sv
// branch_target_predictor: combinational next-PC prediction for IF using a
// tagged BTB plus a PHT of saturating counters (bimodal or gshare), trained
// on the clock edge from EX resolution.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of branch_target_predictor_if (fetch in, prediction
//              out, EX resolution in)
module branch_target_predictor
  import branch_target_predictor_pkg::*;
#(
  parameter int unsigned DWIDTH    = 32,
  parameter int unsigned BTB_SIZE  = 16,
  parameter int unsigned PHT_SIZE  = 64,
  parameter int unsigned CNT_BITS  = 2,
  parameter int unsigned HIST_BITS = 6,
  parameter pred_mode_e  MODE      = PRED_GSHARE
) (
  input logic                    clk,
  input logic                    rst,
  branch_target_predictor_if.slave bus
);

  localparam int unsigned BIDX_W   = $clog2(BTB_SIZE);
  localparam int unsigned PIDX_W   = $clog2(PHT_SIZE);
  localparam int unsigned TAG_W    = DWIDTH - BIDX_W - 2;
  localparam int unsigned CNT_INIT = 1 << (CNT_BITS - 1);

  logic                 r_btb_valid [BTB_SIZE];
  logic [TAG_W-1:0]     r_btb_tag   [BTB_SIZE];
  logic [DWIDTH-1:0]    r_btb_tgt   [BTB_SIZE];
  logic [HIST_BITS-1:0] r_ghr;

  logic [BIDX_W-1:0]    w_if_bidx;
  logic [TAG_W-1:0]     w_if_tag;
  logic [PIDX_W-1:0]    w_if_pidx;
  logic [BIDX_W-1:0]    w_ex_bidx;
  logic [TAG_W-1:0]     w_ex_tag;
  logic [PIDX_W-1:0]    w_ex_pidx;
  logic [CNT_BITS-1:0]  w_if_cnt;
  logic [5:0]           w_opcode;
  logic [15:0]          w_imm;
  logic [DWIDTH-1:0]    w_pc4;
  logic [DWIDTH-1:0]    w_br_tgt;
  logic                 w_hit;
  logic                 w_unused_pc_lsbs;

  assign w_unused_pc_lsbs = ^{bus.if_pc[1:0], bus.ex_pc[1:0]};

  assign w_if_bidx = bus.if_pc[BIDX_W+1:2];
  assign w_if_tag  = bus.if_pc[DWIDTH-1:BIDX_W+2];
  assign w_ex_bidx = bus.ex_pc[BIDX_W+1:2];
  assign w_ex_tag  = bus.ex_pc[DWIDTH-1:BIDX_W+2];

  // gshare folds the history into the low PHT index bits
  assign w_if_pidx = bus.if_pc[PIDX_W+1:2] ^
                     ((MODE == PRED_GSHARE) ? PIDX_W'(r_ghr) : '0);
  assign w_ex_pidx = bus.ex_pc[PIDX_W+1:2] ^
                     ((MODE == PRED_GSHARE) ? PIDX_W'(bus.ex_hist) : '0);

  sat_counter_table #(
    .DEPTH    (PHT_SIZE),
    .CNT_BITS (CNT_BITS),
    .INIT     (CNT_INIT)
  ) u_pht (
    .clk        (clk),
    .rst        (rst),
    .i_rd_idx   (w_if_pidx),
    .o_rd_cnt_c (w_if_cnt),
    .i_upd_en   (bus.ex_valid),
    .i_upd_inc  (bus.ex_taken),
    .i_upd_idx  (w_ex_pidx)
  );

  // Decode and prediction
  always_comb begin
    w_opcode = bus.if_instr[J_TYPE_OP_MSB:J_TYPE_OP_LSB];
    w_imm    = bus.if_instr[I_TYPE_IMM_MSB:I_TYPE_IMM_LSB];
    w_pc4    = bus.if_pc + DWIDTH'(4);
    w_hit    = r_btb_valid[w_if_bidx] && (r_btb_tag[w_if_bidx] == w_if_tag);
    w_br_tgt = w_hit ? r_btb_tgt[w_if_bidx]
                     : w_pc4 + {{(DWIDTH-18){w_imm[15]}}, w_imm, 2'b00};

    bus.if_npc        = w_pc4;
    bus.if_pred_taken = 1'b0;
    bus.if_btb_hit    = w_hit;
    bus.if_hist       = r_ghr;

    case (w_opcode)
      OPCODE_J, OPCODE_JAL: begin
        bus.if_npc        = {w_pc4[DWIDTH-1:28],
                             bus.if_instr[J_TYPE_ADDR_MSB:J_TYPE_ADDR_LSB], 2'b00};
        bus.if_pred_taken = 1'b1;
      end
      OPCODE_BEQ: begin
        bus.if_pred_taken = w_if_cnt[CNT_BITS-1];
        bus.if_npc        = w_if_cnt[CNT_BITS-1] ? w_br_tgt : w_pc4;
      end
      default: ;
    endcase
  end

  // BTB fill on taken resolutions; non-speculative history update
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(BTB_SIZE); i++) begin
        r_btb_valid[i] <= 1'b0;
        r_btb_tag[i]   <= '0;
        r_btb_tgt[i]   <= '0;
      end
      r_ghr <= '0;
    end else if (bus.ex_valid) begin
      if (bus.ex_taken) begin
        r_btb_valid[w_ex_bidx] <= 1'b1;
        r_btb_tag[w_ex_bidx]   <= w_ex_tag;
        r_btb_tgt[w_ex_bidx]   <= bus.ex_target;
      end
      r_ghr <= HIST_BITS'({r_ghr, bus.ex_taken});
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
module tb_branch_target_predictor;
  import branch_target_predictor_pkg::*;

  typedef struct {
    int          dut;
    logic [31:0] npc;
    logic        taken;
    logic        hit;
    logic [31:0] hist;
  } pred_t;

  localparam logic [31:0] BEQ_M2 = 32'h1000_FFFE;  // beq, imm = -2
  localparam logic [31:0] J_40   = 32'h0800_0040;  // j, addr26 = 0x40
  localparam logic [31:0] JAL_80 = 32'h0C00_0080;
  localparam logic [31:0] ADD_I  = 32'h0000_0020;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  branch_target_predictor_if #(.DWIDTH(32), .HIST_BITS(6)) bif0 ();
  branch_target_predictor_if #(.DWIDTH(32), .HIST_BITS(2)) bif1 ();

  branch_target_predictor #(
    .DWIDTH(32), .BTB_SIZE(16), .PHT_SIZE(64), .CNT_BITS(2),
    .HIST_BITS(6), .MODE(PRED_BIMODAL)
  ) u_dut0 (.clk(clk), .rst(rst), .bus(bif0));

  branch_target_predictor #(
    .DWIDTH(32), .BTB_SIZE(16), .PHT_SIZE(64), .CNT_BITS(2),
    .HIST_BITS(2), .MODE(PRED_GSHARE)
  ) u_dut1 (.clk(clk), .rst(rst), .bus(bif1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: index 0 = bimodal / 6-bit history, 1 = gshare / 2-bit
  bit          m_valid [2][16];
  logic [31:0] m_tag   [2][16];
  logic [31:0] m_tgt   [2][16];
  int          m_pht   [2][64];
  int          m_ghr   [2];
  int          m_hbits [2] = '{6, 2};

  pred_t       sb_q [$];
  logic [31:0] obs_npc   [2];
  logic        obs_taken [2];
  logic        obs_hit   [2];
  logic [31:0] obs_hist  [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic pred_t model_pred(int d, logic [31:0] pc, logic [31:0] instr);
    pred_t p;
    logic [31:0] pc4, imm_sx, addr;
    logic [5:0]  op;
    int bidx, pidx;
    pc4    = pc + 32'd4;
    op     = instr[31:26];
    imm_sx = {{14{instr[15]}}, instr[15:0], 2'b00};
    addr   = {6'b0, instr[25:0]};
    bidx   = int'((pc >> 2) & 32'hF);
    pidx   = int'((pc >> 2) & 32'h3F) ^ ((d == 1) ? m_ghr[d] : 0);
    p.dut  = d;
    p.hist = 32'(m_ghr[d]);
    p.hit  = m_valid[d][bidx] && (m_tag[d][bidx] == (pc >> 6));
    if (op == 6'd2 || op == 6'd3) begin
      p.taken = 1'b1;
      p.npc   = (pc4 & 32'hF000_0000) | (addr << 2);
    end else if (op == 6'd4) begin
      p.taken = (m_pht[d][pidx] >= 2);
      p.npc   = p.taken ? (p.hit ? m_tgt[d][bidx] : pc4 + imm_sx) : pc4;
    end else begin
      p.taken = 1'b0;
      p.npc   = pc4;
    end
    return p;
  endfunction

  function automatic void model_update(bit rst_v, bit exv, logic [31:0] expc,
                                       int exhist, bit extaken, logic [31:0] extgt);
    for (int d = 0; d < 2; d++) begin
      if (rst_v) begin
        for (int i = 0; i < 16; i++) begin
          m_valid[d][i] = 1'b0; m_tag[d][i] = '0; m_tgt[d][i] = '0;
        end
        for (int i = 0; i < 64; i++) m_pht[d][i] = 2;
        m_ghr[d] = 0;
      end else if (exv) begin
        int pidx, bidx;
        bidx = int'((expc >> 2) & 32'hF);
        pidx = int'((expc >> 2) & 32'h3F) ^ ((d == 1) ? (exhist & 3) : 0);
        if (extaken) begin
          if (m_pht[d][pidx] < 3) m_pht[d][pidx]++;
          m_valid[d][bidx] = 1'b1;
          m_tag[d][bidx]   = expc >> 6;
          m_tgt[d][bidx]   = extgt;
        end else if (m_pht[d][pidx] > 0) begin
          m_pht[d][pidx]--;
        end
        m_ghr[d] = ((m_ghr[d] << 1) | int'(extaken)) & ((1 << m_hbits[d]) - 1);
      end
    end
  endfunction

  // One cycle: drive at negedge, push expectations, sample before posedge,
  // then advance the reference model on the edge.
  task automatic step(input bit rst_v, input bit do_chk, input logic [31:0] pc,
                      input logic [31:0] instr, input bit exv, input logic [31:0] expc,
                      input int exhist, input bit extaken, input logic [31:0] extgt);
    pred_t e;
    @(negedge clk);
    #1;
    rst = rst_v;
    bif0.if_pc = pc;  bif0.if_instr = instr;  bif0.ex_valid = exv;
    bif0.ex_pc = expc; bif0.ex_hist = 6'(exhist); bif0.ex_taken = extaken;
    bif0.ex_target = extgt;
    bif1.if_pc = pc;  bif1.if_instr = instr;  bif1.ex_valid = exv;
    bif1.ex_pc = expc; bif1.ex_hist = 2'(exhist); bif1.ex_taken = extaken;
    bif1.ex_target = extgt;
    if (do_chk) begin
      sb_q.push_back(model_pred(0, pc, instr));
      sb_q.push_back(model_pred(1, pc, instr));
    end
    #2;
    obs_npc[0] = bif0.if_npc; obs_taken[0] = bif0.if_pred_taken;
    obs_hit[0] = bif0.if_btb_hit; obs_hist[0] = 32'(bif0.if_hist);
    obs_npc[1] = bif1.if_npc; obs_taken[1] = bif1.if_pred_taken;
    obs_hit[1] = bif1.if_btb_hit; obs_hist[1] = 32'(bif1.if_hist);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq($sformatf("sb%0d_npc", e.dut), obs_npc[e.dut], e.npc);
      check_eq($sformatf("sb%0d_taken", e.dut), 32'(obs_taken[e.dut]), 32'(e.taken));
      check_eq($sformatf("sb%0d_hit", e.dut), 32'(obs_hit[e.dut]), 32'(e.hit));
      check_eq($sformatf("sb%0d_hist", e.dut), obs_hist[e.dut], e.hist);
    end
    @(posedge clk);
    model_update(rst_v, exv, expc, exhist, extaken, extgt);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;

    step(1, 0, 32'h40, BEQ_M2, 0, 0, 0, 0, 0);
    step(1, 0, 32'h40, BEQ_M2, 0, 0, 0, 0, 0);

    // After reset: weakly taken, BTB miss, computed target
    step(0, 1, 32'h40, BEQ_M2, 0, 0, 0, 0, 0);
    check_eq("rst_npc", obs_npc[0], 32'h3C);
    check_eq("rst_taken", 32'(obs_taken[0]), 32'd1);
    check_eq("rst_hit", 32'(obs_hit[0]), 32'd0);
    check_eq("rst_hist", obs_hist[1], 32'd0);

    // Three not-taken: 2 -> 1 -> 0 -> 0
    for (int i = 0; i < 3; i++) step(0, 1, 32'h40, BEQ_M2, 1, 32'h40, 0, 0, 0);
    step(0, 1, 32'h40, BEQ_M2, 0, 0, 0, 0, 0);
    check_eq("nt3_npc", obs_npc[0], 32'h44);
    check_eq("nt3_taken", 32'(obs_taken[0]), 32'd0);
    step(0, 1, 32'h40, BEQ_M2, 1, 32'h40, 0, 0, 0);
    step(0, 1, 32'h40, BEQ_M2, 0, 0, 0, 0, 0);
    check_eq("sat0_taken", 32'(obs_taken[0]), 32'd0);

    // Reset concurrent with a taken resolution: update is discarded
    step(1, 1, 32'h40, BEQ_M2, 1, 32'h40, 0, 1, 32'h200);
    step(0, 1, 32'h40, BEQ_M2, 0, 0, 0, 0, 0);
    check_eq("rst2_npc", obs_npc[0], 32'h3C);
    check_eq("rst2_hit", 32'(obs_hit[0]), 32'd0);
    check_eq("rst2_hist", obs_hist[1], 32'd0);

    // Taken with target 0x100; same-cycle read still sees the old entry
    step(0, 1, 32'h40, BEQ_M2, 1, 32'h40, 0, 1, 32'h100);
    check_eq("wr_same_cyc_hit", 32'(obs_hit[0]), 32'd0);
    step(0, 1, 32'h40, BEQ_M2, 0, 0, 0, 0, 0);
    check_eq("btb_hit", 32'(obs_hit[0]), 32'd1);
    check_eq("btb_npc", obs_npc[0], 32'h100);
    step(0, 1, 32'h80, BEQ_M2, 0, 0, 0, 0, 0);
    check_eq("alias_hit", 32'(obs_hit[0]), 32'd0);
    check_eq("alias_npc", obs_npc[0], 32'h7C);

    // Drain gshare entry 0x13, then build GHR = 2'b11
    step(0, 1, 32'h40, ADD_I, 1, 32'h40, 3, 0, 0);
    step(0, 1, 32'h40, ADD_I, 1, 32'h40, 3, 0, 0);
    step(0, 1, 32'h40, ADD_I, 1, 32'h40, 0, 1, 32'h100);
    step(0, 1, 32'h40, ADD_I, 1, 32'h40, 0, 1, 32'h100);
    step(0, 1, 32'h40, BEQ_M2, 0, 0, 0, 0, 0);
    check_eq("gs_hist", obs_hist[1], 32'd3);
    check_eq("gs_taken", 32'(obs_taken[1]), 32'd0);
    check_eq("gs_npc", obs_npc[1], 32'h44);
    check_eq("bm_taken", 32'(obs_taken[0]), 32'd1);

    // Jumps bypass BTB/PHT
    step(0, 1, 32'h1000_0010, J_40, 0, 0, 0, 0, 0);
    check_eq("j_npc", obs_npc[0], 32'h1000_0100);
    check_eq("j_taken", 32'(obs_taken[0]), 32'd1);
    step(0, 1, 32'hFFFF_FFF0, JAL_80, 0, 0, 0, 0, 0);
    step(0, 1, 32'h40, BEQ_M2, 0, 0, 0, 0, 0);
    step(0, 1, 32'h44, 32'h1000_0010, 0, 0, 0, 0, 0);

    // Mixed traffic against the reference model
    for (int i = 0; i < 60; i++) begin
      logic [31:0] pc, instr, expc, tgt;
      int kind;
      pc   = 32'($urandom_range(0, 63)) << 2;
      kind = int'($urandom_range(0, 3));
      case (kind)
        0:       instr = {6'd4, 10'($urandom), 16'($urandom)};
        1:       instr = {6'd2, 26'($urandom)};
        2:       instr = {6'd3, 26'($urandom)};
        default: instr = {6'd0, 26'($urandom)};
      endcase
      expc = 32'($urandom_range(0, 63)) << 2;
      tgt  = 32'($urandom) & 32'hFFFF_FFFC;
      step(0, 1, pc, instr, bit'($urandom_range(0, 1)), expc,
           int'($urandom_range(0, 63)), bit'($urandom_range(0, 1)), tgt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
